// File: rtl/hazard_pkg.sv
// Shared types for the RV32I hazard/pipeline-control unit.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_NONE = 2'b00,
      FWD_W    = 2'b01,
      FWD_M    = 2'b10
   } fwd_sel_t;

endpackage

// File: rtl/hazard_ctrl_perf_counter.sv
// Wrapping performance counter with synchronous clear that beats increment.
module perf_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] q
);

   logic [CNT_W-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (clr)      q_d = '0;
      else if (inc) q_d = q_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) q_q <= '0;
      else     q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard / pipeline-control unit for the 5-stage RV32I core: stage valids,
// stall/flush generation, operand forwarding and performance counters.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int FWD_EN = 1,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] rs1D,
   input  logic [REG_AW-1:0] rs2D,
   input  logic              use_rs1D,
   input  logic              use_rs2D,
   input  logic [REG_AW-1:0] rs1E,
   input  logic [REG_AW-1:0] rs2E,
   input  logic [REG_AW-1:0] rdE,
   input  logic [REG_AW-1:0] rdM,
   input  logic [REG_AW-1:0] rdW,
   input  logic              regwriteE,
   input  logic              regwriteM,
   input  logic              regwriteW,
   input  logic              resultsrcE,
   input  logic              pcsrcE,
   input  logic              ex_busy,
   input  logic              cnt_clr,
   output logic              stall_f,
   output logic              stall_d,
   output logic              stall_e,
   output logic              flush_d,
   output logic              flush_e,
   output logic              flush_m,
   output fwd_sel_t          fwd_a_e,
   output fwd_sel_t          fwd_b_e,
   output logic              fwd_a_d,
   output logic              fwd_b_d,
   output logic              valid_d,
   output logic              valid_e,
   output logic              valid_m,
   output logic              valid_w,
   output logic [CNT_W-1:0]  cyc_cnt,
   output logic [CNT_W-1:0]  ret_cnt,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   logic vd_q, ve_q, vm_q, vw_q;
   logic vd_d, ve_d, vm_d, vw_d;
   logic luse, ilck, dep, busy, brk;

   // x0 is never a real producer, so it can never create a hazard.
   function automatic logic hit(input logic v, input logic we,
                                input logic [REG_AW-1:0] rd,
                                input logic [REG_AW-1:0] r);
      return v & we & (rd == r) & (rd != '0);
   endfunction

   always_comb begin
      luse = vd_q & ve_q & resultsrcE &
             ((use_rs1D & hit(ve_q, regwriteE, rdE, rs1D)) |
              (use_rs2D & hit(ve_q, regwriteE, rdE, rs2D)));
      dep  = vd_q &
             ((use_rs1D & (hit(ve_q, regwriteE, rdE, rs1D) |
                           hit(vm_q, regwriteM, rdM, rs1D) |
                           hit(vw_q, regwriteW, rdW, rs1D))) |
              (use_rs2D & (hit(ve_q, regwriteE, rdE, rs2D) |
                           hit(vm_q, regwriteM, rdM, rs2D) |
                           hit(vw_q, regwriteW, rdW, rs2D))));
      ilck = (FWD_EN == 0) & dep;
      // A busy unit only matters when E holds a real instruction; this also
      // makes reset drop every stall immediately.
      busy = ve_q & ex_busy;
      brk  = ve_q & pcsrcE & ~ex_busy;

      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_m = 1'b0;
      if (busy) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         stall_e = 1'b1;
         flush_m = 1'b1;
      end else if (brk) begin
         flush_d = 1'b1;
         flush_e = 1'b1;
      end else if (luse | ilck) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         flush_e = 1'b1;
      end
   end

   always_comb begin
      fwd_a_e = FWD_NONE;
      fwd_b_e = FWD_NONE;
      fwd_a_d = 1'b0;
      fwd_b_d = 1'b0;
      if (FWD_EN != 0) begin
         if (hit(vm_q, regwriteM, rdM, rs1E))      fwd_a_e = FWD_M;
         else if (hit(vw_q, regwriteW, rdW, rs1E)) fwd_a_e = FWD_W;
         if (hit(vm_q, regwriteM, rdM, rs2E))      fwd_b_e = FWD_M;
         else if (hit(vw_q, regwriteW, rdW, rs2E)) fwd_b_e = FWD_W;
         fwd_a_d = use_rs1D & hit(vw_q, regwriteW, rdW, rs1D);
         fwd_b_d = use_rs2D & hit(vw_q, regwriteW, rdW, rs2D);
      end
   end

   always_comb begin
      vd_d = flush_d ? 1'b0 : stall_d ? vd_q : 1'b1;
      ve_d = flush_e ? 1'b0 : stall_e ? ve_q : vd_q;
      vm_d = flush_m ? 1'b0 : ve_q;
      vw_d = vm_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vd_q <= 1'b0;
         ve_q <= 1'b0;
         vm_q <= 1'b0;
         vw_q <= 1'b0;
      end else begin
         vd_q <= vd_d;
         ve_q <= ve_d;
         vm_q <= vm_d;
         vw_q <= vw_d;
      end
   end

   assign valid_d = vd_q;
   assign valid_e = ve_q;
   assign valid_m = vm_q;
   assign valid_w = vw_q;

   perf_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
      .clk(clk), .rst(rst), .clr(cnt_clr), .inc(1'b1),    .q(cyc_cnt));
   perf_counter #(.CNT_W(CNT_W)) u_ret_cnt (
      .clk(clk), .rst(rst), .clr(cnt_clr), .inc(vw_q),    .q(ret_cnt));
   perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk(clk), .rst(rst), .clr(cnt_clr), .inc(stall_d), .q(stall_cnt));
   perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk(clk), .rst(rst), .clr(cnt_clr), .inc(brk),     .q(flush_cnt));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a forwarding instance (u_fwd) and a
// full-interlock instance (u_ilk) share stimulus.
module tb_hazard_ctrl;
   import hazard_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
   logic       use_rs1D, use_rs2D, regwriteE, regwriteM, regwriteW;
   logic       resultsrcE, pcsrcE, ex_busy, cnt_clr;

   logic       sf1, sd1, se1, fd1, fe1, fm1, fad1, fbd1, vd1, ve1, vm1, vw1;
   fwd_sel_t   fae1, fbe1;
   logic [31:0] cyc1, ret1, stl1, fls1;
   logic       sf0, sd0, se0, fd0, fe0, fm0, fad0, fbd0, vd0, ve0, vm0, vw0;
   fwd_sel_t   fae0, fbe0;
   logic [31:0] cyc0, ret0, stl0, fls0;

   hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .CNT_W(32)) u_fwd (
      .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .use_rs1D(use_rs1D),
      .use_rs2D(use_rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .rdM(rdM),
      .rdW(rdW), .regwriteE(regwriteE), .regwriteM(regwriteM),
      .regwriteW(regwriteW), .resultsrcE(resultsrcE), .pcsrcE(pcsrcE),
      .ex_busy(ex_busy), .cnt_clr(cnt_clr), .stall_f(sf1), .stall_d(sd1),
      .stall_e(se1), .flush_d(fd1), .flush_e(fe1), .flush_m(fm1),
      .fwd_a_e(fae1), .fwd_b_e(fbe1), .fwd_a_d(fad1), .fwd_b_d(fbd1),
      .valid_d(vd1), .valid_e(ve1), .valid_m(vm1), .valid_w(vw1),
      .cyc_cnt(cyc1), .ret_cnt(ret1), .stall_cnt(stl1), .flush_cnt(fls1));

   hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .CNT_W(32)) u_ilk (
      .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .use_rs1D(use_rs1D),
      .use_rs2D(use_rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .rdM(rdM),
      .rdW(rdW), .regwriteE(regwriteE), .regwriteM(regwriteM),
      .regwriteW(regwriteW), .resultsrcE(resultsrcE), .pcsrcE(pcsrcE),
      .ex_busy(ex_busy), .cnt_clr(cnt_clr), .stall_f(sf0), .stall_d(sd0),
      .stall_e(se0), .flush_d(fd0), .flush_e(fe0), .flush_m(fm0),
      .fwd_a_e(fae0), .fwd_b_e(fbe0), .fwd_a_d(fad0), .fwd_b_d(fbd0),
      .valid_d(vd0), .valid_e(ve0), .valid_m(vm0), .valid_w(vw0),
      .cyc_cnt(cyc0), .ret_cnt(ret0), .stall_cnt(stl0), .flush_cnt(fls0));

   // Observed word: {vD,vE,vM,vW, stall f/d/e, flush d/e/m, fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d}
   logic [15:0] w1, w0;
   assign w1 = {vd1, ve1, vm1, vw1, sf1, sd1, se1, fd1, fe1, fm1, fae1, fbe1, fad1, fbd1};
   assign w0 = {vd0, ve0, vm0, vw0, sf0, sd0, se0, fd0, fe0, fm0, fae0, fbe0, fad0, fbd0};

   typedef struct packed {
      logic [4:0] rs1d, rs2d;
      logic       u1, u2;
      logic [4:0] rs1e, rs2e, rde;
      logic       we, ld;
      logic [4:0] rdm;
      logic       wm;
      logic [4:0] rdw;
      logic       ww, pc, busy;
   } stim_t;

   typedef struct packed {
      logic        sel;   // 1: forwarding instance, 0: interlock instance
      logic [15:0] w;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   function automatic stim_t st(input int rs1d, input int rs2d, input int u1,
                                input int u2, input int rs1e, input int rs2e,
                                input int rde, input int we, input int ld,
                                input int rdm, input int wm, input int rdw,
                                input int ww, input int pc, input int busy);
      stim_t s;
      s.rs1d = 5'(rs1d); s.rs2d = 5'(rs2d); s.u1 = 1'(u1); s.u2 = 1'(u2);
      s.rs1e = 5'(rs1e); s.rs2e = 5'(rs2e); s.rde = 5'(rde);
      s.we = 1'(we); s.ld = 1'(ld); s.rdm = 5'(rdm); s.wm = 1'(wm);
      s.rdw = 5'(rdw); s.ww = 1'(ww); s.pc = 1'(pc); s.busy = 1'(busy);
      return s;
   endfunction

   function automatic logic [15:0] ew(input int v, input int s, input int f,
                                      input fwd_sel_t a, input fwd_sel_t b,
                                      input int ad, input int bd);
      return {4'(v), 3'(s), 3'(f), a, b, 1'(ad), 1'(bd)};
   endfunction

   task automatic apply(input stim_t s);
      rs1D = s.rs1d; rs2D = s.rs2d; use_rs1D = s.u1; use_rs2D = s.u2;
      rs1E = s.rs1e; rs2E = s.rs2e; rdE = s.rde; regwriteE = s.we;
      resultsrcE = s.ld; rdM = s.rdm; regwriteM = s.wm; rdW = s.rdw;
      regwriteW = s.ww; pcsrcE = s.pc; ex_busy = s.busy;
   endtask

   localparam stim_t IDLE = '0;

   task automatic test_reset();
      logic [15:0] e [6];
      exp_t x;
      apply(IDLE);
      cnt_clr = 1'b0;
      rst = 1'b1;
      exp_q.push_back({1'b1, 16'h0000});
      exp_q.push_back({1'b0, 16'h0000});
      @(negedge clk);
      x = exp_q.pop_front(); n_chk++;
      if (w1 !== x.w) $display("FAIL reset_fwd: got %h want %h", w1, x.w); else n_pass++;
      x = exp_q.pop_front(); n_chk++;
      if (w0 !== x.w) $display("FAIL reset_ilk: got %h want %h", w0, x.w); else n_pass++;
      n_chk++;
      if ({cyc1, ret1, stl1, fls1} !== 128'd0)
         $display("FAIL reset_cnt: got %0d %0d %0d %0d want 0", cyc1, ret1, stl1, fls1);
      else n_pass++;
      rst = 1'b0;
      @(posedge clk); #1;
      e = '{ew('b1000,0,0,FWD_NONE,FWD_NONE,0,0), ew('b1100,0,0,FWD_NONE,FWD_NONE,0,0),
            ew('b1110,0,0,FWD_NONE,FWD_NONE,0,0), ew('b1111,0,0,FWD_NONE,FWD_NONE,0,0),
            ew('b1111,0,0,FWD_NONE,FWD_NONE,0,0), ew('b1111,0,0,FWD_NONE,FWD_NONE,0,0)};
      for (int i = 0; i < 6; i++) begin
         apply(IDLE);
         exp_q.push_back({1'b1, e[i]});
         @(negedge clk);
         x = exp_q.pop_front(); n_chk++;
         if (w1 !== x.w) $display("FAIL fill cyc%0d: got %h want %h", i, w1, x.w); else n_pass++;
         @(posedge clk); #1;
      end
      n_chk++;
      if (cyc1 !== 32'd7 || ret1 !== 32'd3)
         $display("FAIL fill_cnt: got cyc=%0d ret=%0d want cyc=7 ret=3", cyc1, ret1);
      else n_pass++;
   endtask

   task automatic test_load_use();
      stim_t s [5];
      logic [15:0] e [5];
      exp_t x;
      n_chk++;
      if (stl1 !== 32'd0 || fls1 !== 32'd0)
         $display("FAIL lu_pre_cnt: got stall=%0d flush=%0d want 0 0", stl1, fls1);
      else n_pass++;
      s = '{st(5,1,1,1, 9,9, 5,1,1, 0,0, 0,0, 0,0),
            st(5,1,1,1, 9,9, 0,0,0, 5,1, 0,0, 0,0),
            st(0,0,0,0, 5,1, 0,0,0, 0,0, 5,1, 0,0),
            IDLE, IDLE};
      e = '{ew('b1111,'b110,'b010,FWD_NONE,FWD_NONE,0,0),
            ew('b1011,0,0,FWD_NONE,FWD_NONE,0,0),
            ew('b1101,0,0,FWD_W,FWD_NONE,0,0),
            ew('b1110,0,0,FWD_NONE,FWD_NONE,0,0),
            ew('b1111,0,0,FWD_NONE,FWD_NONE,0,0)};
      for (int i = 0; i < 5; i++) begin
         apply(s[i]);
         exp_q.push_back({1'b1, e[i]});
         @(negedge clk);
         x = exp_q.pop_front(); n_chk++;
         if (w1 !== x.w) $display("FAIL load_use cyc%0d: got %h want %h", i, w1, x.w); else n_pass++;
         @(posedge clk); #1;
      end
      n_chk++;
      if (stl1 !== 32'd1) $display("FAIL lu_stall_cnt: got %0d want 1", stl1); else n_pass++;
   endtask

   task automatic test_branch();
      stim_t s [6];
      logic [15:0] e [6];
      exp_t x;
      s = '{st(5,1,1,1, 9,9, 5,1,1, 0,0, 0,0, 1,0), IDLE, IDLE, IDLE, IDLE, IDLE};
      e = '{ew('b1111,0,'b110,FWD_NONE,FWD_NONE,0,0),
            ew('b0011,0,0,FWD_NONE,FWD_NONE,0,0),
            ew('b1001,0,0,FWD_NONE,FWD_NONE,0,0),
            ew('b1100,0,0,FWD_NONE,FWD_NONE,0,0),
            ew('b1110,0,0,FWD_NONE,FWD_NONE,0,0),
            ew('b1111,0,0,FWD_NONE,FWD_NONE,0,0)};
      for (int i = 0; i < 6; i++) begin
         apply(s[i]);
         exp_q.push_back({1'b1, e[i]});
         @(negedge clk);
         x = exp_q.pop_front(); n_chk++;
         if (w1 !== x.w) $display("FAIL branch cyc%0d: got %h want %h", i, w1, x.w); else n_pass++;
         @(posedge clk); #1;
      end
      n_chk++;
      if (fls1 !== 32'd1 || stl1 !== 32'd1)
         $display("FAIL br_cnt: got flush=%0d stall=%0d want 1 1", fls1, stl1);
      else n_pass++;
   endtask

   task automatic test_busy();
      stim_t s [9];
      logic [15:0] e [9];
      exp_t x;
      s = '{st(0,0,0,0, 0,0, 0,0,0, 0,0, 0,0, 1,1),
            st(0,0,0,0, 0,0, 0,0,0, 0,0, 0,0, 1,1),
            st(0,0,0,0, 0,0, 0,0,0, 0,0, 0,0, 1,1),
            st(0,0,0,0, 0,0, 0,0,0, 0,0, 0,0, 1,0),
            IDLE, IDLE, IDLE, IDLE, IDLE};
      e = '{ew('b1111,'b111,'b001,FWD_NONE,FWD_NONE,0,0),
            ew('b1101,'b111,'b001,FWD_NONE,FWD_NONE,0,0),
            ew('b1100,'b111,'b001,FWD_NONE,FWD_NONE,0,0),
            ew('b1100,0,'b110,FWD_NONE,FWD_NONE,0,0),
            ew('b0010,0,0,FWD_NONE,FWD_NONE,0,0),
            ew('b1001,0,0,FWD_NONE,FWD_NONE,0,0),
            ew('b1100,0,0,FWD_NONE,FWD_NONE,0,0),
            ew('b1110,0,0,FWD_NONE,FWD_NONE,0,0),
            ew('b1111,0,0,FWD_NONE,FWD_NONE,0,0)};
      for (int i = 0; i < 9; i++) begin
         apply(s[i]);
         exp_q.push_back({1'b1, e[i]});
         @(negedge clk);
         x = exp_q.pop_front(); n_chk++;
         if (w1 !== x.w) $display("FAIL busy cyc%0d: got %h want %h", i, w1, x.w); else n_pass++;
         @(posedge clk); #1;
      end
      n_chk++;
      if (stl1 !== 32'd4 || fls1 !== 32'd2)
         $display("FAIL busy_cnt: got stall=%0d flush=%0d want 4 2", stl1, fls1);
      else n_pass++;
   endtask

   task automatic test_fwd();
      stim_t s [5];
      logic [15:0] e [5];
      exp_t x;
      s = '{st(0,0,0,0, 7,3, 0,0,0, 7,1, 7,1, 0,0),
            st(0,0,0,0, 0,0, 0,0,0, 0,1, 0,1, 0,0),
            st(4,4,0,1, 0,4, 0,0,0, 0,0, 4,1, 0,0),
            st(4,4,1,1, 4,4, 0,0,0, 4,0, 4,0, 0,0),
            st(2,0,1,0, 2,0, 0,0,0, 5,1, 2,1, 0,0)};
      e = '{ew('b1111,0,0,FWD_M,FWD_NONE,0,0),
            ew('b1111,0,0,FWD_NONE,FWD_NONE,0,0),
            ew('b1111,0,0,FWD_NONE,FWD_W,0,1),
            ew('b1111,0,0,FWD_NONE,FWD_NONE,0,0),
            ew('b1111,0,0,FWD_W,FWD_NONE,1,0)};
      for (int i = 0; i < 5; i++) begin
         apply(s[i]);
         exp_q.push_back({1'b1, e[i]});
         @(negedge clk);
         x = exp_q.pop_front(); n_chk++;
         if (w1 !== x.w) $display("FAIL fwd cyc%0d: got %h want %h", i, w1, x.w); else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] e [4];
      exp_t x;
      apply(st(5,1,1,1, 9,9, 5,1,1, 0,0, 0,0, 0,0));
      exp_q.push_back({1'b1, ew('b1111,'b110,'b010,FWD_NONE,FWD_NONE,0,0)});
      @(negedge clk);
      x = exp_q.pop_front(); n_chk++;
      if (w1 !== x.w) $display("FAIL mid_pre: got %h want %h", w1, x.w); else n_pass++;
      #2 rst = 1'b1;
      exp_q.push_back({1'b1, 16'h0000});
      #1;
      x = exp_q.pop_front(); n_chk++;
      if (w1 !== x.w) $display("FAIL mid_async: got %h want %h", w1, x.w); else n_pass++;
      n_chk++;
      if ({cyc1, ret1, stl1, fls1} !== 128'd0)
         $display("FAIL mid_cnt: got %0d %0d %0d %0d want 0", cyc1, ret1, stl1, fls1);
      else n_pass++;
      apply(IDLE);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      e = '{ew('b1000,0,0,FWD_NONE,FWD_NONE,0,0), ew('b1100,0,0,FWD_NONE,FWD_NONE,0,0),
            ew('b1110,0,0,FWD_NONE,FWD_NONE,0,0), ew('b1111,0,0,FWD_NONE,FWD_NONE,0,0)};
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({1'b1, e[i]});
         @(negedge clk);
         x = exp_q.pop_front(); n_chk++;
         if (w1 !== x.w) $display("FAIL refill cyc%0d: got %h want %h", i, w1, x.w); else n_pass++;
         @(posedge clk); #1;
      end
      cnt_clr = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      n_chk++;
      if (cyc1 !== 32'd0 || ret1 !== 32'd0)
         $display("FAIL clr: got cyc=%0d ret=%0d want 0 0", cyc1, ret1);
      else n_pass++;
      @(posedge clk); #1;
      n_chk++;
      if (cyc1 !== 32'd1 || ret1 !== 32'd1)
         $display("FAIL post_clr: got cyc=%0d ret=%0d want 1 1", cyc1, ret1);
      else n_pass++;
   endtask

   task automatic test_interlock();
      stim_t s [6];
      logic [15:0] e [6];
      exp_t x;
      s = '{st(3,2,1,1, 0,0, 0,0,0, 3,1, 0,0, 0,0),
            st(3,2,1,1, 0,0, 0,0,0, 0,0, 3,1, 0,0),
            st(3,2,1,1, 0,0, 0,0,0, 0,0, 0,0, 0,0),
            IDLE,
            st(0,0,1,1, 0,0, 0,1,0, 0,1, 0,1, 0,0),
            IDLE};
      e = '{ew('b1111,'b110,'b010,FWD_NONE,FWD_NONE,0,0),
            ew('b1011,'b110,'b010,FWD_NONE,FWD_NONE,0,0),
            ew('b1001,0,0,FWD_NONE,FWD_NONE,0,0),
            ew('b1100,0,0,FWD_NONE,FWD_NONE,0,0),
            ew('b1110,0,0,FWD_NONE,FWD_NONE,0,0),
            ew('b1111,0,0,FWD_NONE,FWD_NONE,0,0)};
      for (int i = 0; i < 6; i++) begin
         apply(s[i]);
         exp_q.push_back({1'b0, e[i]});
         @(negedge clk);
         x = exp_q.pop_front(); n_chk++;
         if ((x.sel ? w1 : w0) !== x.w)
            $display("FAIL interlock cyc%0d: got %h want %h", i, w0, x.w);
         else n_pass++;
         @(posedge clk); #1;
      end
      n_chk++;
      if (stl0 !== 32'd2) $display("FAIL ilk_stall_cnt: got %0d want 2", stl0); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch();
      test_busy();
      test_fwd();
      test_reset_mid();
      test_interlock();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation ran past 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
